arith_core: RTL and testbench
=============================

Name: arith_core

Overview:
- Minimal single-cycle arithmetic datapath: a 32x32 register file (`register_file`) feeding a combinational ALU (`alu`).
- The ALU result is written back to the destination register on every rising clock edge.
- Each cycle executes one register-register or register-immediate operation, driven directly by the decoded fields.
- Used as a stepping stone and test vehicle before the pipelined CPU.

Parameters:
- XLEN, 32, data word width (Word).
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.
- IMM_W, 12, immediate field width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- op  input  4  AluOp code.
- dst  input  5  destination register address.
- src1  input  5  first source register address.
- src2  input  5  second source register address.
- has_immediate  input  1  1: ALU operand B = sign-extended imm; 0: operand B = register[src2].
- imm  input  12  signed immediate.
- out  output  32  combinational ALU result; this is also the write-back data.
- alu_error  output  1  high while op is not a defined encoding.

Behaviour:
- Register reads are combinational and asynchronous: v1 = R[src1], v2 = R[src2].
- Register 0 always reads 0; writes to it are discarded.
- Operand B = has_immediate ? sign-extend(imm) to 32 bits : v2.
- ALU is purely combinational. Encodings:
  - ADD 0: A+B, mod 2^32.
  - SUB 1: A-B, mod 2^32.
  - AND 2, OR 3, XOR 4: bitwise.
  - SLL 5, SRL 6, SRA 7: shift A by B[4:0].
  - SLT 8: signed A<B, result 1 or 0.
  - SLTU 9: unsigned A<B, result 1 or 0.
- Undefined op codes 10–15: out = 0, alu_error = 1. alu_error = 0 for all defined codes.
- Write-back, rising edge with reset high: R[dst] <= out when dst != 0. Write enable is permanently asserted; every cycle writes.
- Read-during-write to the same register: reads return the old value during that cycle; the new value is visible after the edge.
- Latency: result on out in the same cycle (combinational); architectural state updates at the next rising edge.
- Reset, rising edge with reset low: all registers cleared to 0 and no write-back that cycle. Reset asserted mid-sequence discards the pending write.
- No X propagation: the register array is fully defined after the first reset.

Optional Feature:
- Macro: ARITH_CORE_DUMP_EN.
- When defined, register_file provides a task `dump()` that prints every non-zero register as "rN: <decimal value>", one per line, in ascending N. Simulation only; no effect on hardware.
- When undefined, the task is absent and the RTL is otherwise identical.

Decomposition:
- Shared package: Word (32b), RegAddress (5b), Immediate (12b signed), AluOp enum with the encodings above.
- Sub-module `alu`: ports error, op, a, b, result.
- Sub-module `register_file`: ports clk, reset, write_enable, write_addr, read_addr1, read_addr2, write_data, read_data1, read_data2.
- arith_core itself holds only the operand-B mux and the instantiations.

Test Plan:
- Reset then immediate chain:
  - ADD r1=r0+10 → r1=10.
  - ADD r1=r1+40 → r1=50.
  - ADD r2=r1+10 → r2=60.
  - ADD r3=r2+1 → r3=61.
  - ADD r4=r3+1 → r4=62.
- Register ops after the chain: SUB r5=r4-r1 → 12; AND r6=r1&r2 → 48. Final dump shows r1 50, r2 60, r3 61, r4 62, r5 12, r6 48.
- Write r0: ADD r0=r0+5 → out=5, r0 still reads 0 next cycle.
- Sign extension and compares, with r1=0:
  - imm=-1 (0xFFF), ADD r7=r0+imm → 0xFFFFFFFF.
  - SLT r8=r7<r1 → 1.
  - SLTU r9=r7<r1 → 0.
- Shifts, r7=0xFFFFFFFF: SRA by 4 → 0xFFFFFFFF; SRL by 4 → 0x0FFFFFFF; SLL 1 by 31 → 0x80000000.
- op=12 → alu_error=1, out=0. Reset low for one edge mid-stream → all registers 0 and the pending write is dropped.

Source files
------------

// File: rtl/arith_core_pkg.sv
// Shared types and widths for the arith_core single-cycle datapath.
package arith_core_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);
    localparam int IMM_W  = 12;

    typedef logic [XLEN-1:0]          word_t;
    typedef logic [REG_AW-1:0]        reg_address_t;
    typedef logic signed [IMM_W-1:0]  immediate_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    function automatic word_t sign_extend_imm(input immediate_t imm);
        return word_t'({{(XLEN-IMM_W){imm[IMM_W-1]}}, imm});
    endfunction

endpackage

// File: rtl/arith_core_alu.sv
// Purely combinational ALU; undefined opcodes yield zero and raise error.
module alu
    import arith_core_pkg::*;
(
    output logic    error,
    input  alu_op_t op,
    input  word_t   a,
    input  word_t   b,
    output word_t   result
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [4:0]             shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        error  = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = word_t'(a_s >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  error  = 1'b1;
        endcase
    end

endmodule

// File: rtl/arith_core_register_file.sv
// 32x32 register file: async reads, sync write, r0 hardwired to zero.
// Define ARITH_CORE_DUMP_EN to get a simulation-only dump() task.
module register_file
    import arith_core_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         write_enable,
    input  reg_address_t write_addr,
    input  reg_address_t read_addr1,
    input  reg_address_t read_addr2,
    input  word_t        write_data,
    output word_t        read_data1,
    output word_t        read_data2
);

    word_t regs [NREGS];

    // Reads see the pre-edge contents, so same-cycle read-during-write returns the old value.
    assign read_data1 = (read_addr1 == '0) ? '0 : regs[read_addr1];
    assign read_data2 = (read_addr2 == '0) ? '0 : regs[read_addr2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_addr != '0)) begin
            regs[write_addr] <= write_data;
        end
    end

`ifdef ARITH_CORE_DUMP_EN
    task automatic dump();
        for (int i = 1; i < NREGS; i++) begin
            if (regs[i] != '0) begin
                $display("r%0d: %0d", i, regs[i]);
            end
        end
    endtask
`else
`endif

endmodule

// File: rtl/arith_core.sv
// Single-cycle datapath top: operand-B select between sign-extended imm and R[src2].
// Optional ARITH_CORE_DUMP_EN enables register_file.dump() in simulation.
module arith_core
    import arith_core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [4:0]  dst,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic        has_immediate,
    input  logic [11:0] imm,
    output logic [31:0] out,
    output logic        alu_error
);

    word_t v1;
    word_t v2;
    word_t operand_b;

    assign operand_b = has_immediate ? sign_extend_imm(immediate_t'(imm)) : v2;

    register_file u_regfile (
        .clk          (clk),
        .reset        (reset),
        .write_enable (1'b1),
        .write_addr   (reg_address_t'(dst)),
        .read_addr1   (reg_address_t'(src1)),
        .read_addr2   (reg_address_t'(src2)),
        .write_data   (out),
        .read_data1   (v1),
        .read_data2   (v2)
    );

    alu u_alu (
        .error  (alu_error),
        .op     (alu_op_t'(op)),
        .a      (v1),
        .b      (operand_b),
        .result (out)
    );

endmodule

// File: tb/tb_arith_core.sv
// Self-checking bench for arith_core: directed plan plus randomized ops vs. a behavioural model.
module tb_arith_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        has_immediate;
    logic [11:0] imm;
    logic [31:0] out;
    logic        alu_error;

    int errors = 0;
    int checks = 0;
    logic [31:0] mregs [32];

    arith_core dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .dst           (dst),
        .src1          (src1),
        .src2          (src2),
        .has_immediate (has_immediate),
        .imm           (imm),
        .out           (out),
        .alu_error     (alu_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int o, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (o)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            7: return $unsigned($signed(a) >>> sh);
            8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // One instruction: check combinational out/alu_error against the model, then commit at the edge.
    task automatic step(input int o, input int d, input int s1, input int s2,
                        input bit hi, input int im, input string name);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [11:0] im12;
        bit exp_err;
        im12 = im[11:0];
        op = o[3:0]; dst = d[4:0]; src1 = s1[4:0]; src2 = s2[4:0];
        has_immediate = hi; imm = im12;
        a = mregs[s1];
        b = hi ? {{20{im12[11]}}, im12} : mregs[s2];
        exp = ref_alu(o, a, b);
        exp_err = (o > 9);
        @(negedge clk);
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL %s out: got %h want %h", name, out, exp);
        end
        checks++;
        if (alu_error !== exp_err) begin
            errors++;
            $display("FAIL %s alu_error: got %b want %b", name, alu_error, exp_err);
        end
        @(posedge clk); #1;
        if (reset && d != 0) mregs[d] = exp;
    endtask

    // Read R[r] through the ALU (ADD r+0 into r0) and compare with a fixed value.
    task automatic expect_reg(input int r, input logic [31:0] want, input string name);
        op = 4'd0; dst = 5'd0; src1 = r[4:0]; src2 = 5'd0;
        has_immediate = 1'b1; imm = 12'd0;
        @(negedge clk);
        checks++;
        if (out !== want) begin
            errors++;
            $display("FAIL %s r%0d: got %h want %h", name, r, out, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    endtask

    task automatic test_reset();
        op = 4'd0; dst = 5'd0; src1 = 5'd0; src2 = 5'd0; has_immediate = 1'b1; imm = 12'd0;
        do_reset();
        for (int i = 0; i < 32; i++) expect_reg(i, 32'd0, "reset_clear");
    endtask

    task automatic test_imm_chain();
        step(0, 1, 0, 0, 1, 10, "chain_r1_10");
        expect_reg(1, 32'd10, "chain");
        step(0, 1, 1, 0, 1, 40, "chain_r1_50");
        step(0, 2, 1, 0, 1, 10, "chain_r2_60");
        step(0, 3, 2, 0, 1, 1,  "chain_r3_61");
        step(0, 4, 3, 0, 1, 1,  "chain_r4_62");
        expect_reg(1, 32'd50, "chain");
        expect_reg(2, 32'd60, "chain");
        expect_reg(3, 32'd61, "chain");
        expect_reg(4, 32'd62, "chain");
    endtask

    task automatic test_reg_ops();
        step(1, 5, 4, 1, 0, 0, "sub_r5");
        step(2, 6, 1, 2, 0, 0, "and_r6");
        expect_reg(5, 32'd12, "reg_ops");
        expect_reg(6, 32'd48, "reg_ops");
`ifdef ARITH_CORE_DUMP_EN
        dut.u_regfile.dump();
`endif
    endtask

    task automatic test_r0_write();
        step(0, 0, 0, 0, 1, 5, "write_r0");
        expect_reg(0, 32'd0, "r0_stays_zero");
    endtask

    task automatic test_sign_cmp();
        do_reset();
        step(0, 7, 0, 0, 1, -1, "sext_r7");
        step(8, 8, 7, 1, 0, 0, "slt_r8");
        step(9, 9, 7, 1, 0, 0, "sltu_r9");
        expect_reg(7, 32'hFFFF_FFFF, "sext");
        expect_reg(8, 32'd1, "slt");
        expect_reg(9, 32'd0, "sltu");
    endtask

    task automatic test_shifts();
        step(7, 10, 7, 0, 1, 4, "sra_r10");
        step(6, 11, 7, 0, 1, 4, "srl_r11");
        step(0, 12, 0, 0, 1, 1, "one_r12");
        step(5, 13, 12, 0, 1, 31, "sll_r13");
        expect_reg(10, 32'hFFFF_FFFF, "sra");
        expect_reg(11, 32'h0FFF_FFFF, "srl");
        expect_reg(13, 32'h8000_0000, "sll");
    endtask

    task automatic test_error();
        step(12, 14, 7, 0, 1, 3, "undef_op12");
        expect_reg(14, 32'd0, "undef_writes_zero");
        for (int o = 10; o < 16; o++) step(o, 0, 7, 7, 0, 0, "undef_sweep");
    endtask

    task automatic test_mid_reset();
        step(0, 1, 0, 0, 1, 5, "pre_reset_r1");
        op = 4'd0; dst = 5'd2; src1 = 5'd0; src2 = 5'd0; has_immediate = 1'b1; imm = 12'd9;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        expect_reg(1, 32'd0, "mid_reset_clear");
        expect_reg(2, 32'd0, "mid_reset_drop");
        expect_reg(7, 32'd0, "mid_reset_clear");
    endtask

    task automatic test_random();
        int o;
        for (int n = 0; n < 300; n++) begin
            o = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            step(o, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4095)), "random");
        end
        for (int i = 0; i < 32; i++) expect_reg(i, mregs[i], "random_final");
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_imm_chain();
        test_reg_ops();
        test_r0_write();
        test_sign_cmp();
        test_shifts();
        test_error();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
